// File: rtl/pyramid_dump_pkg.sv
// Shared types and helpers for the image-pyramid UART dump engine.
package pyramid_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_WAIT,
    ST_SEND,
    ST_CSUM,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Pixel count of octave `oct` for a pyramid whose top level is top_w x top_h.
  function automatic int unsigned level_pixels(input int unsigned top_w,
                                               input int unsigned top_h,
                                               input int unsigned oct);
    return (top_w >> oct) * (top_h >> oct);
  endfunction

endpackage

// File: rtl/pyramid_dump_byte_tx_reg.sv
// Valid/ready hold register: a loaded byte stays presented, unchanged, until it is accepted.
module byte_tx_reg (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load_in,
  input  logic [7:0] data_in,
  input  logic       ready_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       accept_out
);

  logic [7:0] data_q;
  logic       valid_q;

  assign accept_out = valid_q & ready_in;
  assign data_out   = data_q;
  assign valid_out  = valid_q;

  // A load is only honoured when nothing is held, so a presented byte can never change.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else if (load_in && !valid_q) begin
      data_q  <= data_in;
      valid_q <= 1'b1;
    end else if (accept_out) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pyramid_dump.sv
// Streams pyramid levels from BRAM to a UART as framed bytes: A5, octave, scale, pixels, XOR.
//   state | meaning
//   IDLE  | waiting for start_in
//   HDR   | sending sync, octave and scale bytes
//   RD    | one-cycle read strobe at addr_q
//   WAIT  | BRAM latency; capture pixel on last cycle
//   SEND  | pixel byte presented until accepted
//   CSUM  | XOR checksum byte
//   NEXT  | advance scale, then octave
//   DONE  | one-cycle done pulse
module pyramid_dump
  import pyramid_dump_pkg::*;
#(
  parameter int TOP_WIDTH    = 64,
  parameter int TOP_HEIGHT   = 64,
  parameter int BIT_DEPTH    = 8,
  parameter int NUM_OCTAVES  = 3,
  parameter int NUM_SCALES   = 3,
  parameter int READ_LATENCY = 2,
  localparam int OCT_W  = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1,
  localparam int SCL_W  = (NUM_SCALES > 1) ? $clog2(NUM_SCALES) : 1,
  localparam int ADDR_W = (TOP_WIDTH * TOP_HEIGHT > 1) ? $clog2(TOP_WIDTH * TOP_HEIGHT) : 1,
  localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 all_in,
  input  logic [OCT_W-1:0]     oct_sel_in,
  input  logic [SCL_W-1:0]     scale_sel_in,
  input  logic                 abort_in,
  output logic [OCT_W-1:0]     rd_oct_out,
  output logic [SCL_W-1:0]     rd_scale_out,
  output logic [ADDR_W-1:0]    rd_addr_out,
  output logic                 rd_en_out,
  input  logic [BIT_DEPTH-1:0] rd_data_in,
  output logic [7:0]           tx_data_out,
  output logic                 tx_valid_out,
  input  logic                 tx_ready_in,
  output logic                 busy_out,
  output logic                 done_out
);

  state_e            state_q, state_d;
  logic [OCT_W-1:0]  oct_q, oct_d;
  logic [SCL_W-1:0]  scale_q, scale_d;
  logic              all_q, all_d;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]  wait_q, wait_d;
  logic [7:0]        csum_q, csum_d;
  logic              abort_q, abort_d;

  logic              tx_load;
  logic [7:0]        tx_byte;
  logic              tx_accept;
  logic              abort_now;
  logic [ADDR_W-1:0] last_addr;
  logic              sel_bad;

  byte_tx_reg u_tx (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load_in   (tx_load),
    .data_in   (tx_byte),
    .ready_in  (tx_ready_in),
    .data_out  (tx_data_out),
    .valid_out (tx_valid_out),
    .accept_out(tx_accept)
  );

  assign rd_oct_out   = oct_q;
  assign rd_scale_out = scale_q;
  assign rd_addr_out  = addr_q;
  assign rd_en_out    = (state_q == ST_RD);
  assign done_out     = (state_q == ST_DONE);
  assign busy_out     = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // Abort is made sticky so a short pulse still lands at the next byte boundary.
  assign abort_now = abort_in | abort_q;
  assign last_addr = ADDR_W'(level_pixels(TOP_WIDTH, TOP_HEIGHT, 32'(oct_q)) - 1);
  assign sel_bad   = (32'(oct_sel_in) >= NUM_OCTAVES) || (32'(scale_sel_in) >= NUM_SCALES);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      oct_q     <= '0;
      scale_q   <= '0;
      all_q     <= 1'b0;
      hdr_cnt_q <= 2'd0;
      addr_q    <= '0;
      wait_q    <= '0;
      csum_q    <= 8'h00;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      oct_q     <= oct_d;
      scale_q   <= scale_d;
      all_q     <= all_d;
      hdr_cnt_q <= hdr_cnt_d;
      addr_q    <= addr_d;
      wait_q    <= wait_d;
      csum_q    <= csum_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    oct_d     = oct_q;
    scale_d   = scale_q;
    all_d     = all_q;
    hdr_cnt_d = hdr_cnt_q;
    addr_d    = addr_q;
    wait_d    = wait_q;
    csum_d    = csum_q;
    abort_d   = abort_q | abort_in;
    tx_load   = 1'b0;
    tx_byte   = 8'h00;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start_in && !abort_in) begin
          all_d     = all_in;
          hdr_cnt_d = 2'd0;
          addr_d    = '0;
          csum_d    = 8'h00;
          if (all_in) begin
            oct_d   = '0;
            scale_d = '0;
            state_d = ST_HDR;
          end else if (sel_bad) begin
            state_d = ST_DONE;
          end else begin
            oct_d   = oct_sel_in;
            scale_d = scale_sel_in;
            state_d = ST_HDR;
          end
        end
      end

      ST_HDR: begin
        if (!tx_valid_out) begin
          if (abort_now) begin
            state_d = ST_DONE;
          end else begin
            tx_load = 1'b1;
            case (hdr_cnt_q)
              2'd0:    tx_byte = SYNC_BYTE;
              2'd1:    tx_byte = 8'(oct_q);
              default: tx_byte = 8'(scale_q);
            endcase
          end
        end else if (tx_accept) begin
          if (abort_now)               state_d = ST_DONE;
          else if (hdr_cnt_q == 2'd2)  state_d = ST_RD;
          else                         hdr_cnt_d = hdr_cnt_q + 2'd1;
        end
      end

      ST_RD: begin
        if (abort_now) begin
          state_d = ST_DONE;
        end else begin
          wait_d  = LAT_W'(READ_LATENCY - 1);
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (abort_now) begin
          state_d = ST_DONE;
        end else if (wait_q == '0) begin
          tx_load = 1'b1;
          tx_byte = rd_data_in[7:0];
          state_d = ST_SEND;
        end else begin
          wait_d = wait_q - LAT_W'(1);
        end
      end

      ST_SEND: begin
        if (tx_accept) begin
          csum_d = csum_q ^ tx_data_out;
          if (abort_now)                state_d = ST_DONE;
          else if (addr_q == last_addr) state_d = ST_CSUM;
          else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_RD;
          end
        end
      end

      ST_CSUM: begin
        if (!tx_valid_out) begin
          if (abort_now) begin
            state_d = ST_DONE;
          end else begin
            tx_load = 1'b1;
            tx_byte = csum_q;
          end
        end else if (tx_accept) begin
          state_d = abort_now ? ST_DONE : ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (abort_now || !all_q) begin
          state_d = ST_DONE;
        end else begin
          hdr_cnt_d = 2'd0;
          addr_d    = '0;
          csum_d    = 8'h00;
          state_d   = ST_HDR;
          if (32'(scale_q) < NUM_SCALES - 1) begin
            scale_d = scale_q + SCL_W'(1);
          end else if (32'(oct_q) < NUM_OCTAVES - 1) begin
            scale_d = '0;
            oct_d   = oct_q + OCT_W'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pyramid_dump.sv
// Directed bench for pyramid_dump: a 4x4/2-octave/1-scale instance and a 4x4/2-octave/3-scale instance.
module tb_pyramid_dump;

  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       all_sel = 1'b0;
  logic       abort = 1'b0;
  logic       tx_ready = 1'b1;
  logic       oct_sel_a = 1'b0, scl_sel_a = 1'b0;
  logic       oct_sel_b = 1'b0;
  logic [1:0] scl_sel_b = 2'd0;

  logic       rd_oct_a, rd_scl_a, rd_en_a, tx_valid_a, busy_a, done_a;
  logic [3:0] rd_addr_a;
  logic [7:0] rd_data_a, tx_data_a;
  logic       rd_oct_b, rd_en_b, tx_valid_b, busy_b, done_b;
  logic [1:0] rd_scl_b;
  logic [3:0] rd_addr_b;
  logic [7:0] rd_data_b, tx_data_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pyramid_dump #(.TOP_WIDTH(4), .TOP_HEIGHT(4), .NUM_OCTAVES(2), .NUM_SCALES(1)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_a), .all_in(all_sel),
    .oct_sel_in(oct_sel_a), .scale_sel_in(scl_sel_a), .abort_in(abort),
    .rd_oct_out(rd_oct_a), .rd_scale_out(rd_scl_a), .rd_addr_out(rd_addr_a),
    .rd_en_out(rd_en_a), .rd_data_in(rd_data_a), .tx_data_out(tx_data_a),
    .tx_valid_out(tx_valid_a), .tx_ready_in(tx_ready), .busy_out(busy_a), .done_out(done_a));

  pyramid_dump #(.TOP_WIDTH(4), .TOP_HEIGHT(4), .NUM_OCTAVES(2), .NUM_SCALES(3)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_b), .all_in(all_sel),
    .oct_sel_in(oct_sel_b), .scale_sel_in(scl_sel_b), .abort_in(1'b0),
    .rd_oct_out(rd_oct_b), .rd_scale_out(rd_scl_b), .rd_addr_out(rd_addr_b),
    .rd_en_out(rd_en_b), .rd_data_in(rd_data_b), .tx_data_out(tx_data_b),
    .tx_valid_out(tx_valid_b), .tx_ready_in(tx_ready), .busy_out(busy_b), .done_out(done_b));

  // Pixel contents of level (o,s) at address a.
  function automatic logic [7:0] pix(input int o, input int s, input int a);
    return 8'((o << 6) + (s << 4) + a * 3 + 1);
  endfunction

  logic [7:0] pipe_a [RL];
  logic [7:0] pipe_b [RL];
  always @(posedge clk) begin
    pipe_a[0] <= rd_en_a ? pix(int'(rd_oct_a), int'(rd_scl_a), int'(rd_addr_a)) : 8'h00;
    pipe_b[0] <= rd_en_b ? pix(int'(rd_oct_b), int'(rd_scl_b), int'(rd_addr_b)) : 8'h00;
    for (int i = 1; i < RL; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign rd_data_a = pipe_a[RL-1];
  assign rd_data_b = pipe_b[RL-1];

  logic [7:0] obs_a[$];
  logic [7:0] obs_b[$];
  int         done_cnt_a = 0, done_cnt_b = 0, stab_err = 0;
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(negedge clk) begin
    if (tx_valid_a && tx_ready) obs_a.push_back(tx_data_a);
    if (tx_valid_b && tx_ready) obs_b.push_back(tx_data_b);
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (rst_n && prev_v && !prev_r && (!tx_valid_a || tx_data_a !== prev_d)) stab_err++;
    prev_v = tx_valid_a && rst_n;
    prev_r = tx_ready;
    prev_d = tx_data_a;
  end

  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
  endtask

  task automatic add_frame(input int o, input int s, input int w, input int h);
    logic [7:0] x;
    logic [7:0] p;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(o));
    exp_q.push_back(8'(s));
    for (int a = 0; a < w * h; a++) begin
      p = pix(o, s, a);
      exp_q.push_back(p);
      x = x ^ p;
    end
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input bit use_b, input int budget, input bit rnd_ready);
    int c0;
    int cyc;
    c0  = use_b ? done_cnt_b : done_cnt_a;
    cyc = 0;
    while ((use_b ? done_cnt_b : done_cnt_a) == c0 && cyc < budget) begin
      if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
      step(1);
      cyc++;
    end
    tx_ready = 1'b1;
    chk("done_timeout", 32'((use_b ? done_cnt_b : done_cnt_a) != c0), 32'd1);
  endtask

  task automatic check_stream(input string tag, input bit use_b, input int base);
    int n;
    logic [7:0] got;
    n = use_b ? obs_b.size() : obs_a.size();
    chk($sformatf("%s_len", tag), 32'(n - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < n) begin
        got = use_b ? obs_b[base+i] : obs_a[base+i];
        chk($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp_q[i]));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_valid"}, 32'(tx_valid_a), 32'd0);
    chk({tag, "_rden"}, 32'(rd_en_a), 32'd0);
    chk({tag, "_done"}, 32'(done_a), 32'd0);
    chk({tag, "_data"}, 32'(tx_data_a), 32'd0);
    chk({tag, "_addr"}, 32'(rd_addr_a), 32'd0);
    chk({tag, "_oct"}, 32'(rd_oct_a), 32'd0);
  endtask

  initial begin
    int base;
    int d0;
    int cyc;

    step(3);
    check_reset_outputs("rst");
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    chk("rst_b_valid", 32'(tx_valid_b), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Full dump, always ready.
    exp_q.delete();
    add_frame(0, 0, 4, 4);
    add_frame(1, 0, 2, 2);
    base = obs_a.size();
    d0 = done_cnt_a;
    all_sel = 1'b1;
    pulse_a();
    chk("all_busy", 32'(busy_a), 32'd1);
    wait_done(1'b0, 1000, 1'b0);
    step(3);
    check_stream("all", 1'b0, base);
    chk("all_done_cnt", 32'(done_cnt_a - d0), 32'd1);
    chk("all_idle", 32'(busy_a), 32'd0);

    // Single level oct 1 scale 2.
    exp_q.delete();
    add_frame(1, 2, 2, 2);
    base = obs_b.size();
    d0 = done_cnt_b;
    all_sel = 1'b0;
    oct_sel_b = 1'b1;
    scl_sel_b = 2'd2;
    pulse_b();
    wait_done(1'b1, 500, 1'b0);
    step(3);
    check_stream("single", 1'b1, base);
    chk("single_done_cnt", 32'(done_cnt_b - d0), 32'd1);

    // Random backpressure.
    exp_q.delete();
    add_frame(0, 0, 4, 4);
    add_frame(1, 0, 2, 2);
    base = obs_a.size();
    all_sel = 1'b1;
    pulse_a();
    wait_done(1'b0, 4000, 1'b1);
    step(3);
    check_stream("bp", 1'b0, base);
    chk("bp_stable", 32'(stab_err), 32'd0);

    // Abort while pixel 5 is presented.
    base = obs_a.size();
    d0 = done_cnt_a;
    pulse_a();
    cyc = 0;
    while (obs_a.size() - base < 8 && cyc < 300) begin
      step(1);
      cyc++;
    end
    tx_ready = 1'b0;
    cyc = 0;
    while (!tx_valid_a && cyc < 20) begin
      step(1);
      cyc++;
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(2);
    chk("abort_held_valid", 32'(tx_valid_a), 32'd1);
    chk("abort_held_data", 32'(tx_data_a), 32'(pix(0, 0, 5)));
    tx_ready = 1'b1;
    cyc = 0;
    while (!done_a && cyc < 10) begin
      step(1);
      cyc++;
    end
    chk("abort_latency_ok", 32'(cyc >= 1 && cyc <= RL + 3), 32'd1);
    step(6);
    chk("abort_len", 32'(obs_a.size() - base), 32'd9);
    chk("abort_last", 32'(obs_a[obs_a.size()-1]), 32'(pix(0, 0, 5)));
    chk("abort_done_cnt", 32'(done_cnt_a - d0), 32'd1);
    chk("abort_idle", 32'(busy_a), 32'd0);

    // Reset mid-frame, then a fresh dump.
    pulse_a();
    step(20);
    rst_n = 1'b0;
    step(1);
    check_reset_outputs("midrst");
    step(2);
    rst_n = 1'b1;
    step(2);
    exp_q.delete();
    add_frame(0, 0, 4, 4);
    add_frame(1, 0, 2, 2);
    base = obs_a.size();
    d0 = done_cnt_a;
    pulse_a();
    wait_done(1'b0, 1000, 1'b0);
    step(3);
    check_stream("postrst", 1'b0, base);
    chk("postrst_done_cnt", 32'(done_cnt_a - d0), 32'd1);

    // Repeated start during a dump has no effect.
    base = obs_a.size();
    d0 = done_cnt_a;
    pulse_a();
    step(4);
    all_sel = 1'b0;
    oct_sel_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pulse_a();
      step(6);
    end
    all_sel = 1'b1;
    oct_sel_a = 1'b0;
    wait_done(1'b0, 1000, 1'b0);
    step(3);
    check_stream("restart", 1'b0, base);
    chk("restart_done_cnt", 32'(done_cnt_a - d0), 32'd1);

    // Out-of-range scale select: immediate done, no bytes.
    base = obs_b.size();
    d0 = done_cnt_b;
    all_sel = 1'b0;
    scl_sel_b = 2'd3;
    pulse_b();
    step(2);
    chk("oor_done_cnt", 32'(done_cnt_b - d0), 32'd1);
    chk("oor_bytes", 32'(obs_b.size() - base), 32'd0);
    chk("oor_busy", 32'(busy_b), 32'd0);

    // start together with abort in IDLE starts nothing.
    base = obs_a.size();
    d0 = done_cnt_a;
    all_sel = 1'b1;
    start_a = 1'b1;
    abort = 1'b1;
    step(1);
    start_a = 1'b0;
    abort = 1'b0;
    step(5);
    chk("startabort_busy", 32'(busy_a), 32'd0);
    chk("startabort_bytes", 32'(obs_a.size() - base), 32'd0);
    chk("startabort_done", 32'(done_cnt_a - d0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
